// File: rtl/axis_rr_burst_arbiter.sv
// Round-robin AXI-stream arbiter: grants one producer for a fixed BURST-beat burst into a shared sink.
// Optional stalled-grant revocation is enabled with `define ARB_TIMEOUT_EN.
module axis_rr_burst_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned OUTW    = 24,
  parameter int unsigned BURST   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NREQ-1:0][OUTW-1:0]      IN_AXIS_TDATA,
  input  logic [NREQ-1:0]                IN_AXIS_TVALID,
  output logic [NREQ-1:0]                IN_AXIS_TREADY,
  output logic [OUTW-1:0]                OUT_AXIS_TDATA,
  output logic                           OUT_AXIS_TVALID,
  output logic                           OUT_AXIS_TLAST,
  input  logic                           OUT_AXIS_TREADY,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
  output logic                           busy
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  if (NREQ < 1) begin : g_bad_nreq
    $error("axis_rr_burst_arbiter: NREQ must be >= 1");
  end
  if (BURST < 1) begin : g_bad_burst
    $error("axis_rr_burst_arbiter: BURST must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("axis_rr_burst_arbiter: TIMEOUT must be >= 1");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   ptr_q;
  logic [GW-1:0]   grant_q;
  logic [CW-1:0]   beat_q;
  logic            busy_q;

  logic            pick_vld;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   cand;
  logic [GW-1:0]   ptr_d;
  logic [GW-1:0]   sel;
  logic            beat;

  // First valid requester scanning ptr, ptr+1, ... modulo NREQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = GW'((32'(ptr_q) + k) % NREQ);
      if (!pick_vld && IN_AXIS_TVALID[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign ptr_d = (32'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;
  assign sel   = (state_q == BUSY) ? grant_q : '0;

  always_comb begin
    IN_AXIS_TREADY = '0;
    if (state_q == BUSY) begin
      IN_AXIS_TREADY[grant_q] = OUT_AXIS_TREADY;
    end
  end

  assign OUT_AXIS_TDATA  = IN_AXIS_TDATA[sel];
  assign OUT_AXIS_TVALID = (state_q == BUSY) && IN_AXIS_TVALID[grant_q];
  assign OUT_AXIS_TLAST  = (state_q == BUSY) && (beat_q == LAST_BEAT);
  assign beat            = OUT_AXIS_TVALID && OUT_AXIS_TREADY;

  assign grant_id = grant_q;
  assign busy     = busy_q;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT - 1);

  logic [SW-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          stall_q <= '0;
          if (pick_vld) begin
            grant_q <= pick_idx;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // Only an absent producer stalls the grant; sink backpressure never does.
          if (IN_AXIS_TVALID[grant_q]) begin
            stall_q <= '0;
            if (OUT_AXIS_TREADY) begin
              if (beat_q == LAST_BEAT) begin
                beat_q  <= '0;
                ptr_q   <= ptr_d;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                beat_q <= beat_q + 1'b1;
              end
            end
          end else if (stall_q == STALL_MAX) begin
            stall_q <= '0;
            beat_q  <= '0;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (beat) begin
            if (beat_q == LAST_BEAT) begin
              beat_q  <= '0;
              ptr_q   <= ptr_d;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_axis_rr_burst_arbiter.sv
// Bench for axis_rr_burst_arbiter (NREQ=4, BURST=2): per-cycle vector table plus sink-side scoreboard.
module tb_axis_rr_burst_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned OUTW    = 24;
  localparam int unsigned BURST   = 2;
  localparam int unsigned TIMEOUT = 4;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NREQ-1:0][OUTW-1:0] in_data = '0;
  logic [NREQ-1:0]           in_valid = '0;
  logic [NREQ-1:0]           in_ready;
  logic [OUTW-1:0]           out_data;
  logic                      out_valid;
  logic                      out_last;
  logic                      out_ready = 1'b0;
  logic [1:0]                gid;
  logic                      busy;

  int unsigned tests  = 0;
  int unsigned failed = 0;
  int unsigned cyc    = 0;
  logic [OUTW-1:0] exp_q[$];

  axis_rr_burst_arbiter #(
    .NREQ   (NREQ),
    .OUTW   (OUTW),
    .BURST  (BURST),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .IN_AXIS_TDATA  (in_data),
    .IN_AXIS_TVALID (in_valid),
    .IN_AXIS_TREADY (in_ready),
    .OUT_AXIS_TDATA (out_data),
    .OUT_AXIS_TVALID(out_valid),
    .OUT_AXIS_TLAST (out_last),
    .OUT_AXIS_TREADY(out_ready),
    .grant_id       (gid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic       e_last;
    logic [1:0] e_gid;
    logic       e_busy;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic ordy,
                              input logic [3:0] e_rdy, input logic e_ov, input logic e_last,
                              input logic [1:0] e_gid, input logic e_busy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_last = e_last; v.e_gid = e_gid; v.e_busy = e_busy;
    return v;
  endfunction

  // Producer i presents {i, cycle tag}, so every accepted beat identifies its source and cycle.
  task automatic apply(input vec_t v, input string tag);
    logic [8:0]      act;
    logic [8:0]      exp;
    logic [OUTW-1:0] edat;
    @(posedge clk);
    #1;
    reset     = v.rst;
    in_valid  = v.vld;
    out_ready = v.ordy;
    for (int i = 0; i < NREQ; i++) in_data[i] = {8'(i), 16'(cyc)};
    edat = {8'(v.e_gid), 16'(cyc)};
    if (v.e_ov && v.ordy) exp_q.push_back(edat);
    @(negedge clk);
    act = {in_ready, out_valid, out_last, gid, busy};
    exp = {v.e_rdy, v.e_ov, v.e_last, v.e_gid, v.e_busy};
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cyc=%0d: got rdy=%b tvalid=%b tlast=%b gid=%0d busy=%b, expected rdy=%b tvalid=%b tlast=%b gid=%0d busy=%b",
               tag, cyc, in_ready, out_valid, out_last, gid, busy,
               v.e_rdy, v.e_ov, v.e_last, v.e_gid, v.e_busy);
    end
    if (v.e_ov) begin
      tests++;
      if (out_data !== edat) begin
        failed++;
        $display("FAIL %s_data cyc=%0d: got %h, expected %h", tag, cyc, out_data, edat);
      end
    end
    cyc++;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL sb_unexpected cyc=%0d: got beat %h, expected no beat", cyc, out_data);
      end else begin
        logic [OUTW-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failed++;
          $display("FAIL sb_beat cyc=%0d: got %h, expected %h", cyc, out_data, e);
        end
      end
    end
  end

  vec_t tbl[$];

  initial begin
    // Reset with all requesters valid.
    tbl.push_back(mk(1, 4'hF, 1, 4'h0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(1, 4'hF, 1, 4'h0, 0, 0, 2'd0, 0));
    // Round robin 0,1,2,3,0 with one idle bubble before each burst.
    for (int b = 0; b < 5; b++) begin
      tbl.push_back(mk(0, 4'hF, 1, 4'h0, 0, 0, 2'((b == 0) ? 0 : (b - 1) % 4), 0));
      tbl.push_back(mk(0, 4'hF, 1, 4'(1 << (b % 4)), 1, 0, 2'(b % 4), 1));
      tbl.push_back(mk(0, 4'hF, 1, 4'(1 << (b % 4)), 1, 1, 2'(b % 4), 1));
    end
    // Backpressure on grant 1.
    tbl.push_back(mk(0, 4'b0010, 1, 4'b0000, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 1, 0, 2'd1, 1));
    tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 1, 0, 2'd1, 1));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 1, 1, 2'd1, 1));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 1, 1, 2'd1, 1));
    tbl.push_back(mk(0, 4'b0010, 1, 4'b0010, 1, 1, 2'd1, 1));
    // ptr=2 with reqs 3 and 0: 3 wins, then ptr wraps and 0 wins.
    tbl.push_back(mk(0, 4'b1001, 1, 4'b0000, 0, 0, 2'd1, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 4'b1000, 1, 0, 2'd3, 1));
    tbl.push_back(mk(0, 4'b1001, 1, 4'b1000, 1, 1, 2'd3, 1));
    tbl.push_back(mk(0, 4'b1001, 1, 4'b0000, 0, 0, 2'd3, 0));
    tbl.push_back(mk(0, 4'b1001, 1, 4'b0001, 1, 0, 2'd0, 1));
    tbl.push_back(mk(0, 4'b1001, 1, 4'b0001, 1, 1, 2'd0, 1));
    // Reset during beat 1 of a grant-2 burst while ptr=1.
    tbl.push_back(mk(0, 4'b0100, 1, 4'b0000, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0100, 1, 4'b0100, 1, 0, 2'd2, 1));
    tbl.push_back(mk(1, 4'b0100, 0, 4'b0000, 1, 1, 2'd2, 1));
    tbl.push_back(mk(0, 4'b1101, 1, 4'b0000, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 4'b1101, 1, 4'b0001, 1, 0, 2'd0, 1));
    tbl.push_back(mk(0, 4'b1101, 1, 4'b0001, 1, 1, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 4'b0000, 0, 0, 2'd0, 0));

    foreach (tbl[i]) apply(tbl[i], "vec");

    // Grant 2, one beat, then the producer goes silent.
    apply(mk(0, 4'b0100, 1, 4'b0000, 0, 0, 2'd0, 0), "stall_arb");
    apply(mk(0, 4'b0100, 1, 4'b0100, 1, 0, 2'd2, 1), "stall_beat0");
`ifdef ARB_TIMEOUT_EN
    for (int s = 0; s < 4; s++) apply(mk(0, 4'b0000, 1, 4'b0100, 0, 1, 2'd2, 1), "to_stall");
    apply(mk(0, 4'b1001, 1, 4'b0000, 0, 0, 2'd2, 0), "to_idle");
`else
    for (int s = 0; s < 20; s++) apply(mk(0, 4'b0000, 1, 4'b0100, 0, 1, 2'd2, 1), "hold_stall");
    apply(mk(0, 4'b0100, 1, 4'b0100, 1, 1, 2'd2, 1), "hold_last");
    apply(mk(0, 4'b1001, 1, 4'b0000, 0, 0, 2'd2, 0), "hold_idle");
`endif
    apply(mk(0, 4'b1001, 1, 4'b1000, 1, 0, 2'd3, 1), "next_grant");
    apply(mk(0, 4'b0000, 1, 4'b1000, 0, 1, 2'd3, 1), "next_hold");

    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL sb_drain: got %0d beats outstanding, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
